// File: rtl/md_unit_ctrl.sv
// Multiply/divide sequencer owning HI/LO; optional abort path under `MD_ABORT_EN.
// Latency: mult/multu MULT_CYCLES, div/divu DIV_CYCLES busy cycles; mthi/mtlo commit at next edge.
// Backpressure: md_stall holds F/D whenever a HI/LO-class D-stage instr meets busy or start.
module md_unit_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  md_op,
    input  logic        md_valid,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        d_md_use,
    input  logic        abort,
    output logic        md_stall,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam int CMAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [31:0]    sh_hi;
    logic [31:0]    sh_lo;
    logic           sh_wr;

    logic           is_mul_op;
    logic           is_div_op;
    logic           start;
    logic           abort_now;
    logic           wr_hi;
    logic           wr_lo;

    logic [63:0]    prod_s;
    logic [63:0]    prod_u;
    logic [31:0]    den;
    logic [31:0]    div_q;
    logic [31:0]    div_r;
    logic [31:0]    res_hi;
    logic [31:0]    res_lo;
    logic           res_wr;
    logic [CW-1:0]  start_cnt;

    assign is_mul_op = (md_op == OP_MULT) || (md_op == OP_MULTU);
    assign is_div_op = (md_op == OP_DIV)  || (md_op == OP_DIVU);

`ifdef MD_ABORT_EN
    // An abort in the same cycle as a would-be start wins and suppresses it.
    assign start     = md_valid & (is_mul_op | is_div_op) & ~busy & ~abort;
    assign abort_now = abort;
`else
    logic unused_abort;
    assign unused_abort = abort;
    assign start        = md_valid & (is_mul_op | is_div_op) & ~busy;
    assign abort_now    = 1'b0;
`endif

    // mthi/mtlo only land when the unit is idle; op 7 decodes to nothing.
    assign wr_hi = md_valid & ~busy & (md_op == OP_MTHI);
    assign wr_lo = md_valid & ~busy & (md_op == OP_MTLO);

    // Start cycle itself must stall too, so a following mfhi/mflo never sees stale HI/LO.
    assign md_stall = d_md_use & (busy | start);

    // Full 64-bit products, operands explicitly extended to avoid width surprises.
    assign prod_s = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
    assign prod_u = {32'd0, rs_val} * {32'd0, rt_val};

    // Divider datapath; zero divisor is replaced so the arithmetic stays defined (result unused).
    always_comb begin
        den   = (rt_val == 32'd0) ? 32'd1 : rt_val;
        div_q = 32'd0;
        div_r = 32'd0;
        if (md_op == OP_DIV) begin
            if ((rs_val == 32'h8000_0000) && (den == 32'hFFFF_FFFF)) begin
                div_q = 32'h8000_0000;
                div_r = 32'd0;
            end else begin
                div_q = $signed(rs_val) / $signed(den);
                div_r = $signed(rs_val) % $signed(den);
            end
        end else begin
            div_q = rs_val / den;
            div_r = rs_val % den;
        end
    end

    // Select the value to shadow at start and the busy duration for this op.
    always_comb begin
        res_hi    = 32'd0;
        res_lo    = 32'd0;
        res_wr    = 1'b1;
        start_cnt = CW'(MULT_CYCLES);
        case (md_op)
            OP_MULT: begin
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
            end
            OP_MULTU: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
            end
            OP_DIV, OP_DIVU: begin
                res_hi    = div_r;
                res_lo    = div_q;
                res_wr    = (rt_val != 32'd0);
                start_cnt = CW'(DIV_CYCLES);
            end
            default: begin
                res_wr = 1'b0;
            end
        endcase
    end

    // Sequencer: shadow result at start, count down, commit on the last busy cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            hi    <= 32'd0;
            lo    <= 32'd0;
            sh_hi <= 32'd0;
            sh_lo <= 32'd0;
            sh_wr <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        cnt   <= start_cnt;
                        sh_hi <= res_hi;
                        sh_lo <= res_lo;
                        sh_wr <= res_wr;
                    end else if (wr_hi) begin
                        hi <= rs_val;
                    end else if (wr_lo) begin
                        lo <= rs_val;
                    end
                end
                RUN: begin
                    if (abort_now) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                        sh_wr <= 1'b0;
                    end else if (cnt == CW'(1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                        if (sh_wr) begin
                            hi <= sh_hi;
                            lo <= sh_lo;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Directed bench for md_unit_ctrl: table of single ops plus hand-built multi-cycle sequences.
// Latency: checks exact busy-cycle counts and HI/LO after commit.
// Backpressure: checks md_stall across the start cycle and every busy cycle.
module tb_md_unit_ctrl;

    logic        clk;
    logic        reset_n;
    logic [2:0]  md_op;
    logic        md_valid;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        d_md_use;
    logic        abort;
    logic        md_stall;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    md_unit_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .md_op    (md_op),
        .md_valid (md_valid),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .d_md_use (d_md_use),
        .abort    (abort),
        .md_stall (md_stall),
        .busy     (busy),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic        stall0;
        int          cyc;
        logic [31:0] ehi;
        logic [31:0] elo;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Issue one op with d_md_use held high, then count busy cycles and check the commit.
    task automatic run_vec(input vec_t v);
        int cyc;
        bit stall_ok;
        @(negedge clk);
        md_op    = v.op;
        md_valid = 1'b1;
        rs_val   = v.rs;
        rt_val   = v.rt;
        d_md_use = 1'b1;
        #1 chk({v.name, "_stall_start"}, md_stall, v.stall0);
        @(negedge clk);
        md_valid = 1'b0;
        md_op    = 3'd0;
        cyc      = 0;
        stall_ok = 1'b1;
        while (busy && cyc < 64) begin
            #1;
            if (md_stall !== 1'b1) stall_ok = 1'b0;
            cyc++;
            @(negedge clk);
        end
        #1;
        chk({v.name, "_busy_cycles"}, cyc, v.cyc);
        chk({v.name, "_stall_busy"}, stall_ok, 1'b1);
        chk({v.name, "_stall_after"}, md_stall, 1'b0);
        chk({v.name, "_hi"}, hi, v.ehi);
        chk({v.name, "_lo"}, lo, v.elo);
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
        @(negedge clk);
        md_op    = op;
        md_valid = 1'b1;
        rs_val   = rs;
        rt_val   = rt;
        @(negedge clk);
        md_valid = 1'b0;
        md_op    = 3'd0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_idle_bound"}, busy, 1'b0);
    endtask

    initial begin
        vecs[0]  = '{"mult",     3'd1, 32'hFFFF_FFFE, 32'd3,         1'b1, 5,  32'hFFFF_FFFF, 32'hFFFF_FFFA};
        vecs[1]  = '{"multu",    3'd2, 32'hFFFF_FFFE, 32'd3,         1'b1, 5,  32'h0000_0002, 32'hFFFF_FFFA};
        vecs[2]  = '{"div_neg",  3'd3, 32'hFFFF_FFF9, 32'd2,         1'b1, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3]  = '{"divu_big", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 10, 32'h8000_0000, 32'h0000_0000};
        vecs[4]  = '{"div_ovf",  3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 10, 32'h0000_0000, 32'h8000_0000};
        vecs[5]  = '{"mthi",     3'd5, 32'h0000_1234, 32'd0,         1'b0, 0,  32'h0000_1234, 32'h8000_0000};
        vecs[6]  = '{"div_zero", 3'd3, 32'd5,         32'd0,         1'b1, 10, 32'h0000_1234, 32'h8000_0000};
        vecs[7]  = '{"mtlo",     3'd6, 32'h0000_0055, 32'd0,         1'b0, 0,  32'h0000_1234, 32'h0000_0055};
        vecs[8]  = '{"op7",      3'd7, 32'h0000_0999, 32'd1,         1'b0, 0,  32'h0000_1234, 32'h0000_0055};
        vecs[9]  = '{"divu",     3'd4, 32'd100,       32'd7,         1'b1, 10, 32'h0000_0002, 32'h0000_000E};
        vecs[10] = '{"mult_neg", 3'd1, 32'd7,         32'hFFFF_FFFD, 1'b1, 5,  32'hFFFF_FFFF, 32'hFFFF_FFEB};

        reset_n  = 1'b0;
        md_op    = 3'd0;
        md_valid = 1'b0;
        rs_val   = 32'd0;
        rt_val   = 32'd0;
        d_md_use = 1'b1;
        abort    = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_stall", md_stall, 1'b0);

        for (int i = 0; i < 11; i++) run_vec(vecs[i]);

        // Reset asserted in busy cycle 3 of a divide: clears at once, nothing commits later.
        @(negedge clk);
        md_op = 3'd4; md_valid = 1'b1; rs_val = 32'd100; rt_val = 32'd7;
        @(negedge clk);
        md_valid = 1'b0; md_op = 3'd0;
        repeat (2) @(negedge clk);
        #1 chk("rstmid_busy_before", busy, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("rstmid_busy", busy, 1'b0);
        chk("rstmid_hi", hi, 32'd0);
        chk("rstmid_lo", lo, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (15) @(negedge clk);
        #1;
        chk("rstmid_late_busy", busy, 1'b0);
        chk("rstmid_late_hi", hi, 32'd0);
        chk("rstmid_late_lo", lo, 32'd0);

        // While busy, mthi and a new div are both ignored; the mult still takes 5 cycles.
        @(negedge clk);
        md_op = 3'd1; md_valid = 1'b1; rs_val = 32'd2; rt_val = 32'd3;
        @(negedge clk);
        md_op = 3'd5; rs_val = 32'h0000_AAAA;
        @(negedge clk);
        md_op = 3'd3; rs_val = 32'd9; rt_val = 32'd3;
        @(negedge clk);
        md_valid = 1'b0; md_op = 3'd0;
        #1 chk("ign_busy_c3", busy, 1'b1);
        repeat (2) @(negedge clk);
        #1 chk("ign_busy_c5", busy, 1'b1);
        @(negedge clk);
        #1;
        chk("ign_busy_done", busy, 1'b0);
        chk("ign_hi", hi, 32'd0);
        chk("ign_lo", lo, 32'd6);

        // Abort in busy cycle 2 of mult 2*3 with lo preloaded to 0x55.
        issue(3'd5, 32'h0000_1234, 32'd0);
        issue(3'd6, 32'h0000_0055, 32'd0);
        @(negedge clk);
        md_op = 3'd1; md_valid = 1'b1; rs_val = 32'd2; rt_val = 32'd3;
        @(negedge clk);
        md_valid = 1'b0; md_op = 3'd0;
        @(negedge clk);
        abort = 1'b1;
        #1 chk("abort_busy_c2", busy, 1'b1);
        @(negedge clk);
        abort = 1'b0;
`ifdef MD_ABORT_EN
        #1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_lo", lo, 32'h0000_0055);
        chk("abort_hi", hi, 32'h0000_1234);
        repeat (8) @(negedge clk);
        #1;
        chk("abort_late_lo", lo, 32'h0000_0055);
        // Abort alongside a start suppresses the start.
        @(negedge clk);
        md_op = 3'd3; md_valid = 1'b1; rs_val = 32'd8; rt_val = 32'd2; abort = 1'b1;
        #1 chk("abort_start_stall", md_stall, 1'b0);
        @(negedge clk);
        md_valid = 1'b0; md_op = 3'd0; abort = 1'b0;
        #1;
        chk("abort_start_busy", busy, 1'b0);
        chk("abort_start_lo", lo, 32'h0000_0055);
`else
        wait_idle("noabort");
        #1;
        chk("noabort_lo", lo, 32'd6);
        chk("noabort_hi", hi, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
